// File: rtl/z80_bus_target.sv
// Memory-bus target for the mini Z80 core: RAM window plus an MMIO page with
// an output byte FIFO, an input holding register and a 16-bit timer.
module z80_bus_target #(
   parameter int         RAM_AW     = 14,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] UNMAPPED   = 8'hFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] address,
   input  logic        we,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        irq
);

   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam logic [16:0] RAM_SIZE = 17'd1 << RAM_AW;

   logic [7:0]  ram [2**RAM_AW];
   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr;
   logic        fifo_empty, fifo_full, overflow;
   logic        hold_full;
   logic [7:0]  hold_data;
   logic [15:0] count;
   logic [7:0]  shadow;
   logic        enable, tmr_ovf;

   logic is_ram;
   logic status_wr, tx_push, rx_pop, lo_read, ctl_wr;
   logic fifo_pop, do_push, ovf_set, capture, tmr_clear, tmr_wrap;

   assign is_ram    = {1'b0, address} < RAM_SIZE;
   assign status_wr = we  && (address == 16'hFF00);
   assign tx_push   = we  && (address == 16'hFF01);
   assign rx_pop    = !we && (address == 16'hFF02);
   assign lo_read   = !we && (address == 16'hFF03);
   assign ctl_wr    = we  && (address == 16'hFF05);

   // Full/empty come from the extra wrap bit on each pointer.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_mem[rd_ptr[PW-1:0]];
   assign fifo_pop   = out_valid && out_ready;
   assign do_push    = tx_push && (!fifo_full || fifo_pop);
   assign ovf_set    = tx_push && fifo_full && !fifo_pop;

   assign in_ready  = !hold_full;
   assign capture   = in_valid && in_ready;
   assign tmr_clear = ctl_wr && wdata[1];
   assign tmr_wrap  = enable && !tmr_clear && (count == 16'hFFFF);
   assign irq       = hold_full || tmr_ovf;

   // Storage arrays keep their contents across reset.
   always_ff @(posedge clock) begin
      if (we && is_ram)
         ram[address[RAM_AW-1:0]] <= wdata;
      if (do_push)
         fifo_mem[wr_ptr[PW-1:0]] <= wdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (ovf_set)
            overflow <= 1'b1;
         else if (status_wr && wdata[2])
            overflow <= 1'b0;
      end
   end

   // A capture needs in_ready, so it never collides with a pop of a full register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_full <= 1'b0;
         hold_data <= 8'h00;
      end else if (capture) begin
         hold_full <= 1'b1;
         hold_data <= in_data;
      end else if (rx_pop) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count   <= 16'h0000;
         shadow  <= 8'h00;
         enable  <= 1'b0;
         tmr_ovf <= 1'b0;
      end else begin
         if (tmr_clear)
            count <= 16'h0000;
         else if (enable)
            count <= count + 16'd1;
         if (lo_read)
            shadow <= count[15:8];
         if (ctl_wr)
            enable <= wdata[0];
         if (tmr_wrap)
            tmr_ovf <= 1'b1;
         else if (status_wr && wdata[4])
            tmr_ovf <= 1'b0;
      end
   end

   always_comb begin
      rdata = UNMAPPED;
      if (is_ram) begin
         rdata = ram[address[RAM_AW-1:0]];
      end else begin
         case (address)
            16'hFF00: rdata = {3'b000, tmr_ovf, hold_full, overflow, fifo_full, fifo_empty};
            16'hFF01: rdata = 8'h00;
            16'hFF02: rdata = hold_data;
            16'hFF03: rdata = count[7:0];
            16'hFF04: rdata = shadow;
            16'hFF05: rdata = {7'b0000000, enable};
            default:  rdata = UNMAPPED;
         endcase
      end
   end

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed testbench for z80_bus_target: RAM, FIFO, input register, timer, reset.
module tb_z80_bus_target;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] address = 16'h8000;
   logic        we = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        irq;

   int pass_count = 0;
   int check_count = 0;

   z80_bus_target dut (
      .clock(clock), .reset_n(reset_n), .address(address), .we(we),
      .wdata(wdata), .rdata(rdata), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic write_bus(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      address = a; we = 1'b1; wdata = d;
      @(posedge clock);
      #1;
      we = 1'b0; address = 16'h8000;
   endtask

   task automatic read_bus(input logic [15:0] a, output logic [7:0] d);
      @(negedge clock);
      address = a; we = 1'b0;
      #1 d = rdata;
      @(posedge clock);
      #1 address = 16'h8000;
   endtask

   task automatic test_reset;
      address = 16'hFF00;
      #1;
      check_count++;
      if (rdata !== 8'h01) $display("FAIL reset_status got %h want 01", rdata); else pass_count++;
      check_count++;
      if ({out_valid, in_ready, irq} !== 3'b010)
         $display("FAIL reset_outputs got %b want 010", {out_valid, in_ready, irq});
      else pass_count++;
      @(negedge clock);
      reset_n = 1'b1;
      address = 16'h8000;
   endtask

   task automatic test_ram;
      logic [7:0] d;
      write_bus(16'h1234, 8'h5A);
      read_bus(16'h1234, d);
      check_count++;
      if (d !== 8'h5A) $display("FAIL ram_readback got %h want 5a", d); else pass_count++;
      read_bus(16'h4000, d);
      check_count++;
      if (d !== 8'hFF) $display("FAIL unmapped_4000 got %h want ff", d); else pass_count++;
      write_bus(16'h0000, 8'h00);
      write_bus(16'h8000, 8'h77);
      read_bus(16'h0000, d);
      check_count++;
      if (d !== 8'h00) $display("FAIL unmapped_write_alias got %h want 00", d); else pass_count++;
      read_bus(16'h8000, d);
      check_count++;
      if (d !== 8'hFF) $display("FAIL unmapped_8000 got %h want ff", d); else pass_count++;
   endtask

   task automatic test_fifo_overflow;
      logic [7:0] d;
      logic [7:0] exp_seq [4];
      exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      out_ready = 1'b0;
      write_bus(16'hFF01, 8'h11);
      check_count++;
      if (out_valid !== 1'b1) $display("FAIL fifo_valid_after_push got %b want 1", out_valid); else pass_count++;
      write_bus(16'hFF01, 8'h22);
      write_bus(16'hFF01, 8'h33);
      write_bus(16'hFF01, 8'h44);
      write_bus(16'hFF01, 8'h55);
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h06) $display("FAIL fifo_full_overflow_status got %h want 06", d); else pass_count++;
      read_bus(16'hFF01, d);
      check_count++;
      if (d !== 8'h00) $display("FAIL txdata_read got %h want 00", d); else pass_count++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         check_count++;
         if (out_valid !== 1'b1 || out_data !== exp_seq[i])
            $display("FAIL fifo_drain_%0d got %b/%h want 1/%h", i, out_valid, out_data, exp_seq[i]);
         else pass_count++;
         out_ready = 1'b1;
      end
      @(negedge clock);
      #1;
      check_count++;
      if (out_valid !== 1'b0) $display("FAIL fifo_empty_after_drain got %b want 0", out_valid); else pass_count++;
      out_ready = 1'b0;
      write_bus(16'hFF00, 8'h04);
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h01) $display("FAIL overflow_clear got %h want 01", d); else pass_count++;
   endtask

   task automatic test_push_pop_full;
      logic [7:0] d;
      logic [7:0] exp_seq [4];
      exp_seq = '{8'hBB, 8'hCC, 8'hDD, 8'hEE};
      out_ready = 1'b0;
      write_bus(16'hFF01, 8'hAA);
      write_bus(16'hFF01, 8'hBB);
      write_bus(16'hFF01, 8'hCC);
      write_bus(16'hFF01, 8'hDD);
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h02) $display("FAIL fifo_full_status got %h want 02", d); else pass_count++;
      @(negedge clock);
      address = 16'hFF01; we = 1'b1; wdata = 8'hEE; out_ready = 1'b1;
      @(posedge clock);
      #1;
      we = 1'b0; address = 16'h8000; out_ready = 1'b0;
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h02) $display("FAIL push_pop_full_status got %h want 02", d); else pass_count++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         check_count++;
         if (out_valid !== 1'b1 || out_data !== exp_seq[i])
            $display("FAIL push_pop_order_%0d got %b/%h want 1/%h", i, out_valid, out_data, exp_seq[i]);
         else pass_count++;
         out_ready = 1'b1;
      end
      @(negedge clock);
      #1;
      check_count++;
      if (out_valid !== 1'b0) $display("FAIL push_pop_empty got %b want 0", out_valid); else pass_count++;
      out_ready = 1'b0;
   endtask

   task automatic test_input;
      logic [7:0] d;
      @(negedge clock);
      in_data = 8'hA7; in_valid = 1'b1;
      #1;
      check_count++;
      if (in_ready !== 1'b1) $display("FAIL in_ready_idle got %b want 1", in_ready); else pass_count++;
      @(posedge clock);
      #1 in_valid = 1'b0;
      check_count++;
      if ({in_ready, irq} !== 2'b01) $display("FAIL hold_capture got %b want 01", {in_ready, irq}); else pass_count++;
      read_bus(16'hFF02, d);
      check_count++;
      if (d !== 8'hA7) $display("FAIL rxdata got %h want a7", d); else pass_count++;
      check_count++;
      if ({in_ready, irq} !== 2'b10) $display("FAIL hold_pop got %b want 10", {in_ready, irq}); else pass_count++;
      @(negedge clock);
      in_data = 8'h3C; in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      check_count++;
      if (in_ready !== 1'b0) $display("FAIL second_capture got %b want 0", in_ready); else pass_count++;
      read_bus(16'hFF02, d);
      check_count++;
      if (d !== 8'h3C || irq !== 1'b0) $display("FAIL second_rxdata got %h/%b want 3c/0", d, irq); else pass_count++;
   endtask

   task automatic test_timer;
      logic [7:0] lo, hi, d;
      int waited;
      write_bus(16'hFF05, 8'h01);
      repeat (300) @(posedge clock);
      read_bus(16'hFF03, lo);
      read_bus(16'hFF04, hi);
      check_count++;
      if ({hi, lo} !== 16'h012C) $display("FAIL timer_snapshot got %h want 012c", {hi, lo}); else pass_count++;
      read_bus(16'hFF05, d);
      check_count++;
      if (d !== 8'h01) $display("FAIL tmr_ctl_read got %h want 01", d); else pass_count++;
      write_bus(16'hFF05, 8'h03);
      read_bus(16'hFF03, d);
      check_count++;
      if (d !== 8'h00) $display("FAIL timer_clear got %h want 00", d); else pass_count++;
      waited = 0;
      while (!irq && waited < 70000) begin
         @(posedge clock);
         waited++;
      end
      #1;
      check_count++;
      if (irq !== 1'b1) $display("FAIL timer_wrap_irq got %b want 1 after %0d cycles", irq, waited); else pass_count++;
      check_count++;
      if (waited < 65530 || waited > 65540) $display("FAIL timer_wrap_cycles got %0d want about 65535", waited); else pass_count++;
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h11) $display("FAIL tmr_ovf_status got %h want 11", d); else pass_count++;
      write_bus(16'hFF05, 8'h00);
      write_bus(16'hFF00, 8'h10);
      read_bus(16'hFF00, d);
      check_count++;
      if (d !== 8'h01 || irq !== 1'b0) $display("FAIL tmr_ovf_clear got %h/%b want 01/0", d, irq); else pass_count++;
   endtask

   task automatic test_async_reset;
      logic [7:0] d;
      write_bus(16'h0100, 8'hC3);
      write_bus(16'hFF05, 8'h01);
      write_bus(16'hFF01, 8'h99);
      @(negedge clock);
      in_data = 8'h5E; in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      check_count++;
      if ({out_valid, in_ready, irq} !== 3'b101)
         $display("FAIL pre_reset_state got %b want 101", {out_valid, in_ready, irq});
      else pass_count++;
      @(posedge clock);
      #2 reset_n = 1'b0;
      address = 16'hFF00;
      #1;
      check_count++;
      if ({out_valid, in_ready, irq} !== 3'b010 || rdata !== 8'h01)
         $display("FAIL async_reset_state got %b/%h want 010/01", {out_valid, in_ready, irq}, rdata);
      else pass_count++;
      address = 16'hFF03;
      #1;
      check_count++;
      if (rdata !== 8'h00) $display("FAIL reset_count got %h want 00", rdata); else pass_count++;
      address = 16'hFF05;
      #1;
      check_count++;
      if (rdata !== 8'h00) $display("FAIL reset_enable got %h want 00", rdata); else pass_count++;
      @(negedge clock);
      reset_n = 1'b1;
      address = 16'h8000;
      read_bus(16'h0100, d);
      check_count++;
      if (d !== 8'hC3) $display("FAIL ram_after_reset got %h want c3", d); else pass_count++;
   endtask

   initial begin
      test_reset();
      test_ram();
      test_fifo_overflow();
      test_push_pop_full();
      test_input();
      test_timer();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
